lsu_mmio_hs: RTL and testbench

- Parametrised next-generation load-store unit with a valid/ready request and a single-cycle response pulse.
- Adds registered (BRAM-friendly) data memory, misalignment/access-fault reporting, synchronised switch/button inputs and a sticky button-event register.
- Sits between the core's MEM stage and data memory plus board I/O (LEDs, HEX, LCD, switches, buttons).
- Exactly one access is outstanding at a time.

---
 rtl/lsu_mmio_pkg.sv | 53 +++++
 rtl/lsu_in_sync.sv | 38 +++
 rtl/lsu_mmio_hs.sv | 216 +++++++++++++++++++++
 tb/tb_lsu_mmio_hs.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mmio_pkg.sv
// ============================================================================
// Module   : lsu_mmio_pkg
// Purpose  : Shared constants, FSM state type and lane helpers for lsu_mmio_hs
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_mmio_pkg;

    localparam logic [2:0] c_f3_byte  = 3'b000;
    localparam logic [2:0] c_f3_half  = 3'b001;
    localparam logic [2:0] c_f3_word  = 3'b010;
    localparam logic [2:0] c_f3_byteu = 3'b100;
    localparam logic [2:0] c_f3_halfu = 3'b101;

    localparam logic [5:0] c_off_ledr    = 6'h00;
    localparam logic [5:0] c_off_ledg    = 6'h10;
    localparam logic [5:0] c_off_hex     = 6'h20;
    localparam logic [5:0] c_off_lcd     = 6'h30;
    localparam logic [4:0] c_off_sw      = 5'h00;
    localparam logic [4:0] c_off_btn     = 5'h10;
    localparam logic [4:0] c_off_btn_evt = 5'h14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   byte_en = 4'b0001 << off;
            2'b01:   byte_en = off[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [2:0] func3,
                                             input logic [1:0] off);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (func3)
            c_f3_byte:  load_ext = {{24{sh[7]}}, sh[7:0]};
            c_f3_half:  load_ext = {{16{sh[15]}}, sh[15:0]};
            c_f3_byteu: load_ext = {24'h0, sh[7:0]};
            c_f3_halfu: load_ext = {16'h0, sh[15:0]};
            default:    load_ext = sh;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_in_sync.sv
// ============================================================================
// Module   : lsu_in_sync
// Purpose  : Multi-stage input synchroniser with rising-edge detect
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_in_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync,
    output logic [WIDTH-1:0] o_rise
);

    logic [WIDTH-1:0] r_chain [STAGES];
    logic [WIDTH-1:0] r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < STAGES; s++) r_chain[s] <= '0;
            r_prev <= '0;
        end else begin
            r_chain[0] <= i_async;
            for (int s = 1; s < STAGES; s++) r_chain[s] <= r_chain[s-1];
            r_prev <= r_chain[STAGES-1];
        end
    end

    assign o_sync = r_chain[STAGES-1];
    assign o_rise = r_chain[STAGES-1] & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/lsu_mmio_hs.sv
// ============================================================================
// Module   : lsu_mmio_hs
// Purpose  : Valid/ready load-store unit for registered data memory and board
//            I/O; define LSU_BTN_EVENT_EN to build the sticky button events.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_mmio_hs
    import lsu_mmio_pkg::*;
#(
    parameter int          DMEM_AW     = 13,
    parameter logic [31:0] DMEM_BASE   = 32'h0000_2000,
    parameter logic [31:0] OMEM_BASE   = 32'h0000_7000,
    parameter logic [31:0] IMEM_BASE   = 32'h0000_7800,
    parameter int          NUM_HEX     = 8,
    parameter int          BTN_W       = 4,
    parameter int          SYNC_STAGES = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic               i_req_we,
    input  logic [2:0]         i_func3,
    input  logic [31:0]        i_addr,
    input  logic [31:0]        i_st_data,
    output logic               o_rsp_valid,
    output logic [31:0]        o_ld_data,
    output logic               o_misalign,
    output logic               o_access_fault,
    input  logic [31:0]        i_io_sw,
    input  logic [BTN_W-1:0]   i_io_btn,
    output logic [31:0]        o_io_ledr,
    output logic [31:0]        o_io_ledg,
    output logic [31:0]        o_io_lcd,
    output logic [NUM_HEX*7-1:0] o_io_hex
);

    localparam int c_lane_depth = 2 ** (DMEM_AW - 2);
    // Hex digit bytes (0x20..0x2F) come out of reset blank.
    localparam logic [511:0] c_omem_rst = {128'h0, {16{8'h7F}}, 256'h0};

    state_t             r_state, w_next;
    logic [DMEM_AW-1:0] r_off;
    logic [2:0]         r_func3;
    logic               r_we, r_misalign, r_fault, r_is_dmem, r_is_omem, r_is_imem;
    logic [31:0]        r_io_q;
    logic [511:0]       r_omem;

    logic        w_accept, w_in_dmem, w_in_omem, w_in_imem, w_misalign, w_fault;
    logic        w_f3_ok, w_map_ok, w_evt_wr_ok, w_store;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_word, w_sw_sync, w_evt_word, w_unused_sw_rise;
    logic [BTN_W-1:0] w_btn_sync, w_btn_rise;

    assign w_accept   = i_req_valid && (r_state == ST_IDLE);
    assign w_in_dmem  = (i_addr[31:DMEM_AW] == DMEM_BASE[31:DMEM_AW]);
    assign w_in_omem  = (i_addr[31:6] == OMEM_BASE[31:6]);
    assign w_in_imem  = (i_addr[31:5] == IMEM_BASE[31:5]);
    assign w_misalign = ((i_func3[1:0] == 2'b01) && i_addr[0]) ||
                        ((i_func3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
    assign w_f3_ok    = i_req_we ? (i_func3 inside {c_f3_byte, c_f3_half, c_f3_word})
                                 : (i_func3 inside {c_f3_byte, c_f3_half, c_f3_word,
                                                    c_f3_byteu, c_f3_halfu});
`ifdef LSU_BTN_EVENT_EN
    assign w_evt_wr_ok = w_in_imem && (i_addr[4:0] == c_off_btn_evt) && (i_func3 == c_f3_word);
`else
    assign w_evt_wr_ok = 1'b0;
`endif
    assign w_map_ok = w_in_dmem || w_in_omem || (w_in_imem && (!i_req_we || w_evt_wr_ok));
    assign w_fault  = !w_misalign && (!w_f3_ok || !w_map_ok);
    assign w_store  = w_accept && i_req_we && !w_misalign && !w_fault;
    assign w_be     = byte_en(i_func3[1:0], i_addr[1:0]);
    assign w_wdata  = (i_func3[1:0] == 2'b00) ? {4{i_st_data[7:0]}} :
                      (i_func3[1:0] == 2'b01) ? {2{i_st_data[15:0]}} : i_st_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        o_req_ready = 1'b0;
        o_rsp_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid)
                    w_next = (!i_req_we && !w_misalign && !w_fault) ? ST_RD : ST_RSP;
            end
            ST_RD:   w_next = ST_RSP;
            ST_RSP: begin
                o_rsp_valid = 1'b1;
                w_next      = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_off      <= '0;
            r_func3    <= '0;
            r_we       <= 1'b0;
            r_misalign <= 1'b0;
            r_fault    <= 1'b0;
            r_is_dmem  <= 1'b0;
            r_is_omem  <= 1'b0;
            r_is_imem  <= 1'b0;
        end else if (w_accept) begin
            r_off      <= i_addr[DMEM_AW-1:0];
            r_func3    <= i_func3;
            r_we       <= i_req_we;
            r_misalign <= w_misalign;
            r_fault    <= w_fault;
            r_is_dmem  <= w_in_dmem;
            r_is_omem  <= w_in_omem;
            r_is_imem  <= w_in_imem;
        end
    end

    // Four byte-wide banks with a registered read port map onto block RAM.
    generate
        for (genvar k = 0; k < 4; k++) begin : g_lane
            logic [7:0] r_mem [c_lane_depth];
            logic [7:0] r_rd_q;
            always_ff @(posedge i_clk) begin
                if (w_store && w_in_dmem && w_be[k])
                    r_mem[i_addr[DMEM_AW-1:2]] <= w_wdata[8*k +: 8];
                if (r_state == ST_RD)
                    r_rd_q <= r_mem[r_off[DMEM_AW-1:2]];
            end
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_omem <= c_omem_rst;
        end else if (w_store && w_in_omem) begin
            for (int k = 0; k < 4; k++)
                if (w_be[k]) r_omem[{i_addr[5:2], 2'(k), 3'b000} +: 8] <= w_wdata[8*k +: 8];
        end
    end

    assign o_io_ledr = r_omem[{c_off_ledr, 3'b000} +: 32];
    assign o_io_ledg = r_omem[{c_off_ledg, 3'b000} +: 32];
    assign o_io_lcd  = r_omem[{c_off_lcd, 3'b000} +: 32];
    generate
        for (genvar k = 0; k < NUM_HEX; k++) begin : g_hex
            assign o_io_hex[7*k +: 7] = r_omem[({c_off_hex, 3'b000} + 9'(8*k)) +: 7];
        end
    endgenerate

    lsu_in_sync #(.WIDTH(32), .STAGES(SYNC_STAGES)) u_sw_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_io_sw),
        .o_sync  (w_sw_sync),
        .o_rise  (w_unused_sw_rise)
    );

    lsu_in_sync #(.WIDTH(BTN_W), .STAGES(SYNC_STAGES)) u_btn_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_io_btn),
        .o_sync  (w_btn_sync),
        .o_rise  (w_btn_rise)
    );

`ifdef LSU_BTN_EVENT_EN
    logic [BTN_W-1:0] r_btn_evt, w_evt_clr;
    assign w_evt_clr = (w_store && w_evt_wr_ok) ? i_st_data[BTN_W-1:0] : '0;
    // Clear is applied before set so a same-cycle edge is never lost.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_btn_evt <= '0;
        else          r_btn_evt <= (r_btn_evt & ~w_evt_clr) | w_btn_rise;
    end
    assign w_evt_word = 32'(r_btn_evt);
`else
    logic w_unused_btn_rise;
    assign w_unused_btn_rise = ^w_btn_rise;
    assign w_evt_word        = '0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_io_q <= '0;
        end else if (r_state == ST_RD) begin
            if (r_is_omem) begin
                r_io_q <= r_omem[{r_off[5:2], 5'b00000} +: 32];
            end else if (r_is_imem) begin
                case ({r_off[4:2], 2'b00})
                    c_off_sw:      r_io_q <= w_sw_sync;
                    c_off_btn:     r_io_q <= 32'(w_btn_sync);
                    c_off_btn_evt: r_io_q <= w_evt_word;
                    default:       r_io_q <= '0;
                endcase
            end else begin
                r_io_q <= '0;
            end
        end
    end

    assign w_word = r_is_dmem ? {g_lane[3].r_rd_q, g_lane[2].r_rd_q,
                                 g_lane[1].r_rd_q, g_lane[0].r_rd_q} : r_io_q;

    assign o_ld_data      = (o_rsp_valid && !r_we && !r_misalign && !r_fault)
                          ? load_ext(w_word, r_func3, r_off[1:0]) : '0;
    assign o_misalign     = o_rsp_valid && r_misalign;
    assign o_access_fault = o_rsp_valid && r_fault;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mmio_hs.sv
// ============================================================================
// Module   : tb_lsu_mmio_hs
// Purpose  : Directed vector bench for lsu_mmio_hs
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_mmio_hs;
    import lsu_mmio_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  func3;
    logic [31:0] addr, st_data, ld_data, io_sw, ledr, ledg, lcd;
    logic        rsp_valid, misalign, access_fault;
    logic [3:0]  io_btn;
    logic [55:0] hex;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lsu_mmio_hs dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_we       (req_we),
        .i_func3        (func3),
        .i_addr         (addr),
        .i_st_data      (st_data),
        .o_rsp_valid    (rsp_valid),
        .o_ld_data      (ld_data),
        .o_misalign     (misalign),
        .o_access_fault (access_fault),
        .i_io_sw        (io_sw),
        .i_io_btn       (io_btn),
        .o_io_ledr      (ledr),
        .o_io_ledg      (ledg),
        .o_io_lcd       (lcd),
        .o_io_hex       (hex)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] ld;
        logic        mis;
        logic        flt;
        int          lat;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Issues one request from a negedge in IDLE and returns the response seen.
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] ld,
                          output logic mis, output logic flt, output int lat);
        logic got;
        req_valid = 1'b1; req_we = we; func3 = f3; addr = a; st_data = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        got = 1'b0; lat = 0; ld = '0; mis = 1'b0; flt = 1'b0;
        for (int c = 1; c <= 6 && !got; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1; lat = c; ld = ld_data; mis = misalign; flt = access_fault;
            end
        end
        @(negedge clk);
        chk("rsp_single_pulse", {63'h0, rsp_valid}, 64'h0);
        chk("ready_after_rsp", {63'h0, req_ready}, 64'h1);
    endtask

    task automatic run(input string name, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] eld,
                       input logic emis, input logic eflt, input int elat);
        logic [31:0] ld;
        logic mis, flt;
        int lat;
        access(we, f3, a, wd, ld, mis, flt, lat);
        chk({name, ".lat"}, 64'(lat), 64'(elat));
        chk({name, ".data"}, {32'h0, ld}, {32'h0, eld});
        chk({name, ".mis"}, {63'h0, mis}, {63'h0, emis});
        chk({name, ".flt"}, {63'h0, flt}, {63'h0, eflt});
    endtask

    initial begin
        int rsp_seen;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; func3 = '0;
        addr = '0; st_data = '0; io_sw = '0; io_btn = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_ready", {63'h0, req_ready}, 64'h1);
        chk("rst_rsp", {63'h0, rsp_valid}, 64'h0);
        chk("rst_hex", {8'h0, hex}, {8'h0, {8{7'h7F}}});
        chk("rst_ledr", {32'h0, ledr}, 64'h0);
        chk("rst_ledg", {32'h0, ledg}, 64'h0);
        chk("rst_lcd", {32'h0, lcd}, 64'h0);

        //           name         we    f3      addr          wdata         ld            mis   flt   lat
        vt.push_back('{"sw_d4",   1'b1, 3'b010, 32'h0000_2004, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 1});
        vt.push_back('{"lw_d4",   1'b0, 3'b010, 32'h0000_2004, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 2});
        vt.push_back('{"sb_d7",   1'b1, 3'b000, 32'h0000_2007, 32'h00000080, 32'h0,        1'b0, 1'b0, 1});
        vt.push_back('{"lb_d7",   1'b0, 3'b000, 32'h0000_2007, 32'h0,        32'hFFFFFF80, 1'b0, 1'b0, 2});
        vt.push_back('{"lbu_d7",  1'b0, 3'b100, 32'h0000_2007, 32'h0,        32'h00000080, 1'b0, 1'b0, 2});
        vt.push_back('{"lw_d4b",  1'b0, 3'b010, 32'h0000_2004, 32'h0,        32'h80ADBEEF, 1'b0, 1'b0, 2});
        vt.push_back('{"lh_d6",   1'b0, 3'b001, 32'h0000_2006, 32'h0,        32'hFFFF80AD, 1'b0, 1'b0, 2});
        vt.push_back('{"lhu_d4",  1'b0, 3'b101, 32'h0000_2004, 32'h0,        32'h0000BEEF, 1'b0, 1'b0, 2});
        vt.push_back('{"lh_mis",  1'b0, 3'b001, 32'h0000_2001, 32'h0,        32'h0,        1'b1, 1'b0, 1});
        vt.push_back('{"sw_ledr", 1'b1, 3'b010, 32'h0000_7000, 32'h11223344, 32'h0,        1'b0, 1'b0, 1});
        vt.push_back('{"sw_mis",  1'b1, 3'b010, 32'h0000_7002, 32'hFFFFFFFF, 32'h0,        1'b1, 1'b0, 1});
        vt.push_back('{"lw_ledr", 1'b0, 3'b010, 32'h0000_7000, 32'h0,        32'h11223344, 1'b0, 1'b0, 2});
        vt.push_back('{"sb_hex3", 1'b1, 3'b000, 32'h0000_7023, 32'h00000079, 32'h0,        1'b0, 1'b0, 1});
        vt.push_back('{"lbu_hex3",1'b0, 3'b100, 32'h0000_7023, 32'h0,        32'h00000079, 1'b0, 1'b0, 2});
        vt.push_back('{"sh_ledg", 1'b1, 3'b001, 32'h0000_7012, 32'h0000ABCD, 32'h0,        1'b0, 1'b0, 1});
        vt.push_back('{"lw_ledg", 1'b0, 3'b010, 32'h0000_7010, 32'h0,        32'hABCD0000, 1'b0, 1'b0, 2});
        vt.push_back('{"lw_unmap",1'b0, 3'b010, 32'h0000_1000, 32'h0,        32'h0,        1'b0, 1'b1, 1});
        vt.push_back('{"ld_badf3",1'b0, 3'b011, 32'h0000_2004, 32'h0,        32'h0,        1'b0, 1'b1, 1});
        vt.push_back('{"st_badf3",1'b1, 3'b100, 32'h0000_2004, 32'h0,        32'h0,        1'b0, 1'b1, 1});
        vt.push_back('{"sw_imem", 1'b1, 3'b010, 32'h0000_7800, 32'h1,        32'h0,        1'b0, 1'b1, 1});
        vt.push_back('{"sw_dtop", 1'b1, 3'b010, 32'h0000_3FFC, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0, 1});
        vt.push_back('{"lw_dtop", 1'b0, 3'b010, 32'h0000_3FFC, 32'h0,        32'hCAFEF00D, 1'b0, 1'b0, 2});
        vt.push_back('{"lw_dend", 1'b0, 3'b010, 32'h0000_4000, 32'h0,        32'h0,        1'b0, 1'b1, 1});
        vt.push_back('{"lw_d4c",  1'b0, 3'b010, 32'h0000_2004, 32'h0,        32'h80ADBEEF, 1'b0, 1'b0, 2});

        foreach (vt[i])
            run(vt[i].name, vt[i].we, vt[i].f3, vt[i].a, vt[i].wd,
                vt[i].ld, vt[i].mis, vt[i].flt, vt[i].lat);

        chk("ledr_kept", {32'h0, ledr}, {32'h0, 32'h11223344});
        chk("ledg_val", {32'h0, ledg}, {32'h0, 32'hABCD0000});
        chk("hex3_val", {57'h0, hex[27:21]}, {57'h0, 7'h79});
        chk("hex0_blank", {57'h0, hex[6:0]}, {57'h0, 7'h7F});
        chk("lcd_zero", {32'h0, lcd}, 64'h0);

        // Synchronised inputs
        io_sw = 32'h12345678; io_btn = 4'b0101;
        repeat (4) @(negedge clk);
        run("lw_sw",  1'b0, 3'b010, 32'h0000_7800, 32'h0, 32'h12345678, 1'b0, 1'b0, 2);
        run("lw_btn", 1'b0, 3'b010, 32'h0000_7810, 32'h0, 32'h00000005, 1'b0, 1'b0, 2);
        io_btn = 4'b0000;
        repeat (4) @(negedge clk);
`ifdef LSU_BTN_EVENT_EN
        run("evt_set",   1'b0, 3'b010, 32'h0000_7814, 32'h0, 32'h00000005, 1'b0, 1'b0, 2);
        run("evt_clr",   1'b1, 3'b010, 32'h0000_7814, 32'h4, 32'h0,        1'b0, 1'b0, 1);
        run("evt_after", 1'b0, 3'b010, 32'h0000_7814, 32'h0, 32'h00000001, 1'b0, 1'b0, 2);
`else
        run("evt_rd0",   1'b0, 3'b010, 32'h0000_7814, 32'h0, 32'h0,        1'b0, 1'b0, 2);
        run("evt_st",    1'b1, 3'b010, 32'h0000_7814, 32'h4, 32'h0,        1'b0, 1'b1, 1);
`endif

        // Reset while a load sits in RD: no response may escape.
        req_valid = 1'b1; req_we = 1'b0; func3 = 3'b010; addr = 32'h0000_2004;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        rsp_seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
        end
        chk("rstrd_no_rsp", 64'(rsp_seen), 64'h0);
        chk("rstrd_ready", {63'h0, req_ready}, 64'h1);
        chk("rstrd_hex", {8'h0, hex}, {8'h0, {8{7'h7F}}});
        chk("rstrd_ledr", {32'h0, ledr}, 64'h0);
        chk("rstrd_ledg", {32'h0, ledg}, 64'h0);
        run("lw_post_rst", 1'b0, 3'b010, 32'h0000_2004, 32'h0, 32'h80ADBEEF, 1'b0, 1'b0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
